// File: rtl/reg_file_if.sv
// Operand-read, write-back and flag-capture bus between decode/ALU and the register file.
interface reg_file_if #(
  parameter int unsigned W = 8,
  parameter int unsigned A = 3
);
  logic [A-1:0] RaddrA;
  logic [A-1:0] RaddrB;
  logic [W-1:0] DataOutA;
  logic [W-1:0] DataOutB;
  logic         WriteEn;
  logic [A-1:0] Waddr;
  logic [W-1:0] DataIn;
  logic         FlagWe;
  logic         ZeroIn;
  logic         ParityIn;
  logic         ZeroFlag;
  logic         ParityFlag;

  modport master (
    output RaddrA, RaddrB, WriteEn, Waddr, DataIn, FlagWe, ZeroIn, ParityIn,
    input  DataOutA, DataOutB, ZeroFlag, ParityFlag
  );

  modport slave (
    input  RaddrA, RaddrB, WriteEn, Waddr, DataIn, FlagWe, ZeroIn, ParityIn,
    output DataOutA, DataOutB, ZeroFlag, ParityFlag
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file (2**A x W) with two combinational read ports,
// one write port, optional write-to-read forwarding and persistent Zero/Parity flags.
module reg_file #(
  parameter int unsigned W      = 8,
  parameter int unsigned A      = 3,
  parameter bit          BYPASS = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  reg_file_if.slave   rf
);
  localparam int unsigned NREG = 1 << A;

  logic [W-1:0] mem_q [NREG];
  logic         zero_q,   zero_d;
  logic         parity_q, parity_d;
  logic [W-1:0] rd_a_c,   rd_b_c;

  // Flags only move on flag-setting ops; otherwise they hold for the branch logic.
  always_comb begin
    zero_d   = zero_q;
    parity_d = parity_q;
    if (rf.FlagWe) begin
      zero_d   = rf.ZeroIn;
      parity_d = rf.ParityIn;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      if (rf.WriteEn) begin
        mem_q[rf.Waddr] <= rf.DataIn;
      end
      zero_q   <= zero_d;
      parity_q <= parity_d;
    end
  end

  // Read ports; forwarding lets an operand see a result written in the same cycle.
  always_comb begin
    rd_a_c = mem_q[rf.RaddrA];
    rd_b_c = mem_q[rf.RaddrB];
    if (BYPASS && rf.WriteEn) begin
      if (rf.RaddrA == rf.Waddr) rd_a_c = rf.DataIn;
      if (rf.RaddrB == rf.Waddr) rd_b_c = rf.DataIn;
    end
    if (!Reset_n) begin
      rd_a_c = '0;
      rd_b_c = '0;
    end
  end

  assign rf.DataOutA   = rd_a_c;
  assign rf.DataOutB   = rd_b_c;
  assign rf.ZeroFlag   = zero_q;
  assign rf.ParityFlag = parity_q;
endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench: a BYPASS=1 and a BYPASS=0 instance see identical stimulus;
// expectations come from an array model of the register file and flags.
module tb_reg_file;
  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [2:0] raddr_a = '0, raddr_b = '0, waddr = '0;
  logic [7:0] data_in = '0;
  logic       write_en = 1'b0, flag_we = 1'b0, zero_in = 1'b0, parity_in = 1'b0;

  reg_file_if #(.W(8), .A(3)) bus_b ();
  reg_file_if #(.W(8), .A(3)) bus_n ();

  assign bus_b.RaddrA = raddr_a;   assign bus_n.RaddrA = raddr_a;
  assign bus_b.RaddrB = raddr_b;   assign bus_n.RaddrB = raddr_b;
  assign bus_b.WriteEn = write_en; assign bus_n.WriteEn = write_en;
  assign bus_b.Waddr = waddr;      assign bus_n.Waddr = waddr;
  assign bus_b.DataIn = data_in;   assign bus_n.DataIn = data_in;
  assign bus_b.FlagWe = flag_we;   assign bus_n.FlagWe = flag_we;
  assign bus_b.ZeroIn = zero_in;   assign bus_n.ZeroIn = zero_in;
  assign bus_b.ParityIn = parity_in; assign bus_n.ParityIn = parity_in;

  reg_file #(.W(8), .A(3), .BYPASS(1'b1)) dut_b (.Clk(Clk), .Reset_n(Reset_n), .rf(bus_b));
  reg_file #(.W(8), .A(3), .BYPASS(1'b0)) dut_n (.Clk(Clk), .Reset_n(Reset_n), .rf(bus_n));

  always #5 Clk = ~Clk;

  typedef struct {
    string      tag;
    logic [7:0] a_b, b_b, a_n, b_n;
    logic       z, p;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] mem_m [8];
  logic       z_m = 1'b0, p_m = 1'b0;

  task automatic chk8(input string tag, input string what, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s %s: got %h expected %h", tag, what, act, req);
    end
  endtask

  task automatic chk1(input string tag, input string what, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s %s: got %b expected %b", tag, what, act, req);
    end
  endtask

  // Monitor: outputs are stable mid-cycle; compare against the oldest expectation.
  always @(negedge Clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk8(e.tag, "byp.DataOutA", bus_b.DataOutA, e.a_b);
      chk8(e.tag, "byp.DataOutB", bus_b.DataOutB, e.b_b);
      chk8(e.tag, "nob.DataOutA", bus_n.DataOutA, e.a_n);
      chk8(e.tag, "nob.DataOutB", bus_n.DataOutB, e.b_n);
      chk1(e.tag, "byp.ZeroFlag", bus_b.ZeroFlag, e.z);
      chk1(e.tag, "byp.ParityFlag", bus_b.ParityFlag, e.p);
      chk1(e.tag, "nob.ZeroFlag", bus_n.ZeroFlag, e.z);
      chk1(e.tag, "nob.ParityFlag", bus_n.ParityFlag, e.p);
    end
  end

  // One clock cycle of stimulus: drive, predict, then commit the model at the edge.
  task automatic cycle(input logic rst, input logic we, input logic [2:0] wa, input logic [7:0] d,
                       input logic [2:0] ra, input logic [2:0] rb,
                       input logic fwe, input logic z, input logic p, input string tag);
    exp_t e;
    Reset_n = rst; write_en = we; waddr = wa; data_in = d;
    raddr_a = ra; raddr_b = rb; flag_we = fwe; zero_in = z; parity_in = p;
    if (!rst) begin
      for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
      z_m = 1'b0; p_m = 1'b0;
    end
    e.tag = tag;
    e.a_n = rst ? mem_m[ra] : 8'h00;
    e.b_n = rst ? mem_m[rb] : 8'h00;
    e.a_b = (rst && we && ra == wa) ? d : e.a_n;
    e.b_b = (rst && we && rb == wa) ? d : e.b_n;
    e.z = z_m;
    e.p = p_m;
    sb_q.push_back(e);
    @(posedge Clk);
    if (rst) begin
      if (we) mem_m[wa] = d;
      if (fwe) begin z_m = z; p_m = p; end
    end
    #1;
  endtask

  task automatic alu_sub(input string tag);
    logic [7:0] diff;
    diff = mem_m[1] - mem_m[2];
    cycle(1, 0, 0, 0, 1, 2, 1, diff == 8'h00, ^diff, tag);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
    @(posedge Clk); #1;
    cycle(0, 1, 3, 8'h55, 3, 0, 1, 1, 1, "reset_hold");
    cycle(1, 1, 0, 8'h9A, 0, 0, 0, 0, 0, "first_write");
    cycle(1, 0, 0, 8'h00, 0, 1, 0, 0, 0, "r0_writable");

    for (int i = 0; i < 8; i++) cycle(1, 1, 3'(i), 8'hA5, 3'(i), 3'(7 - i), 1, 1, 1, "fill_a5");
    cycle(1, 0, 0, 8'h00, 2, 6, 0, 0, 0, "filled");
    cycle(0, 1, 2, 8'h12, 2, 6, 1, 1, 1, "async_reset");
    cycle(1, 0, 0, 8'h00, 5, 7, 0, 0, 0, "after_reset");

    cycle(1, 1, 2, 8'h3C, 0, 0, 0, 0, 0, "wr_r2");
    cycle(1, 1, 5, 8'hC3, 2, 0, 0, 0, 0, "wr_r5");
    cycle(1, 0, 0, 8'h00, 2, 5, 0, 0, 0, "rd_r2_r5");
    cycle(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, "r0_zero");

    cycle(1, 1, 4, 8'h11, 0, 0, 0, 0, 0, "wr_r4");
    cycle(1, 1, 4, 8'h7E, 4, 4, 0, 0, 0, "bypass_both");
    cycle(1, 0, 0, 8'h00, 4, 4, 0, 0, 0, "after_bypass");
    cycle(1, 1, 6, 8'h42, 6, 4, 0, 0, 0, "bypass_a_only");
    cycle(1, 1, 3, 8'h99, 6, 3, 0, 0, 0, "bypass_b_only");

    cycle(1, 0, 0, 8'h00, 0, 0, 1, 1, 0, "flag_set");
    cycle(1, 0, 0, 8'h00, 0, 0, 0, 0, 1, "flag_hold");
    cycle(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, "flag_held");

    cycle(1, 1, 7, 8'hFF, 7, 7, 1, 0, 1, "simultaneous");
    cycle(1, 0, 0, 8'h00, 7, 1, 0, 0, 0, "simul_result");

    cycle(1, 1, 1, 8'd5, 1, 2, 0, 0, 0, "alu_r1_5");
    cycle(1, 1, 2, 8'd5, 1, 2, 0, 0, 0, "alu_r2_5");
    alu_sub("alu_bne_eq");
    cycle(1, 1, 1, 8'd6, 1, 2, 0, 0, 0, "alu_r1_6");
    alu_sub("alu_bne_ne");
    cycle(1, 0, 0, 8'h00, 1, 2, 0, 0, 0, "alu_flags");

    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(49) != 0), 1'($urandom), 3'($urandom), 8'($urandom),
            3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "random");
    end
    cycle(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, "drain");

    @(negedge Clk); #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file and flag register for the 8-bit core.
- Sits directly upstream of the ALU and supplies its InputA and InputB operands.
- Captures the ALU's Zero and Parity outputs into persistent flag bits for the branch logic.
- Accepts one write-back per cycle from the result mux (ALU Out or load data).

Parameters:
W, 8, data width in bits; must match the ALU operand width.
A, 3, register address width; the file holds 2**A registers.
BYPASS, 1, 1 = write-to-read forwarding in the same cycle; 0 = reads always return stored contents.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Reset_n  input  1  asynchronous, active-low reset.
RaddrA  input  A  read address for operand A.
RaddrB  input  A  read address for operand B.
DataOutA  output  W  operand A, drives ALU InputA.
DataOutB  output  W  operand B, drives ALU InputB.
WriteEn  input  1  register write enable.
Waddr  input  A  write address.
DataIn  input  W  write data from the write-back mux.
FlagWe  input  1  flag capture enable; asserted by decode on flag-setting ops.
ZeroIn  input  1  ALU Zero output.
ParityIn  input  1  ALU Parity output.
ZeroFlag  output  1  registered Zero flag.
ParityFlag  output  1  registered Parity flag.

Behaviour:
- Reset:
  - Reset_n low immediately clears all 2**A registers, ZeroFlag and ParityFlag to 0, with no clock required.
  - While Reset_n is low, DataOutA and DataOutB read 0 and all writes and flag captures are ignored.
  - A write presented on the first rising edge after Reset_n deasserts takes effect normally.
- Reads:
  - Combinational, zero latency: DataOutX = reg[RaddrX].
  - Both ports may read the same address.
- Writes:
  - On rising Clk with WriteEn=1, reg[Waddr] <= DataIn.
  - The new value is visible to reads from the cycle after the edge.
  - WriteEn=0 leaves every register unchanged.
  - No register is hardwired; register 0 is writable.
- Bypass:
  - With BYPASS=1, WriteEn=1 and RaddrX==Waddr, DataOutX = DataIn combinationally in the same cycle. This applies to each port independently, including both ports at once.
  - With BYPASS=0, the read returns the old contents during the write cycle.
  - Bypass is suppressed while Reset_n is low.
- Flags:
  - On rising Clk with FlagWe=1, ZeroFlag <= ZeroIn and ParityFlag <= ParityIn.
  - FlagWe=0 holds both flags.
  - Flags are not bypassed: a branch sees the flags from the previous flag-setting op.
- Simultaneous events: WriteEn and FlagWe are fully independent, and both may update on the same edge.
- Width rules:
  - No arithmetic is performed in this block.
  - DataIn is stored unmodified at full W bits.
  - Addresses are exactly A bits, so no out-of-range address exists.
- Timing: a single always_ff drives all state; the read and bypass paths are pure always_comb.

Test Plan:
- Reset: write 8'hA5 to every register, assert Reset_n=0 mid-cycle -> all reads 0 and both flags 0 before the next Clk edge.
- Write/read: write 8'h3C to r2 and 8'hC3 to r5 on consecutive edges; RaddrA=2, RaddrB=5 -> DataOutA=8'h3C, DataOutB=8'hC3; r0 remains 0.
- Bypass (BYPASS=1): r4 holds 8'h11; in one cycle WriteEn=1, Waddr=4, DataIn=8'h7E, RaddrA=RaddrB=4 -> both outputs read 8'h7E in that cycle. With BYPASS=0 the same stimulus -> 8'h11 in that cycle, 8'h7E after the edge.
- Flags: FlagWe=1, ZeroIn=1, ParityIn=0 -> ZeroFlag=1, ParityFlag=0 after the edge. Next cycle FlagWe=0 with ZeroIn=0, ParityIn=1 -> flags hold 1/0.
- Simultaneous: on one edge WriteEn=1, Waddr=7, DataIn=8'hFF and FlagWe=1, ZeroIn=0, ParityIn=1 -> r7=8'hFF, ZeroFlag=0, ParityFlag=1.
- ALU loop: r1=8'd5, r2=8'd5; ALU computes kBNE (InputA-InputB) with result 0, FlagWe=1 -> ZeroFlag=1. Then write r1=8'd6 -> next kBNE gives ZeroFlag=0.
